ramctrl_mp: RTL and testbench

Parametrised multi-port RAM controller; next generation of the two-port (inst/data) line controller.
Serves NUM_PORTS cache-side ports with round-robin arbitration and moves one cache line per request as LINE_BEATS sequential RAM-word beats.
Adds out-of-range detection, a per-beat RAM watchdog timeout, and a line width set by parameter.
Sits between the caches and the RAM model or SDRAM front end.

---
 rtl/ramctrl_mp_pkg.sv | 19 +
 rtl/ramctrl_mp_if.sv | 39 +++
 rtl/ramctrl_mp_rr_arbiter.sv | 29 ++
 rtl/ramctrl_mp.sv | 128 ++++++++++++
 tb/tb_ramctrl_mp.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ramctrl_mp_pkg.sv
// rtl/ramctrl_mp_pkg.sv - shared types and helpers for the multi-port RAM line controller
package ramctrl_mp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        XFER  = 3'd1,
        DONE  = 3'd2,
        ERR   = 3'd3,
        ABORT = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ramctrl_mp_if.sv
// rtl/ramctrl_mp_if.sv - cache-port and RAM-side signal bundle for ramctrl_mp
interface ramctrl_mp_if
    import ramctrl_mp_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int RAM_DW     = 32,
    parameter int LINE_BEATS = 2,
    parameter int LINE_AW    = 22,
    parameter int PORT_AW    = 26
);
    localparam int BB     = clog2(LINE_BEATS);
    localparam int LW     = LINE_BEATS * RAM_DW;
    localparam int RAM_AW = LINE_AW + BB;

    logic [NUM_PORTS-1:0]         p_stb;
    logic [NUM_PORTS-1:0]         p_we;
    logic [NUM_PORTS*PORT_AW-1:0] p_addr;
    logic [NUM_PORTS*LW-1:0]      p_din;
    logic [LW-1:0]                p_dout;
    logic [NUM_PORTS-1:0]         p_ack;
    logic [NUM_PORTS-1:0]         p_timeout;
    logic                         ram_stb;
    logic                         ram_we;
    logic [RAM_AW-1:0]            ram_addr;
    logic [RAM_DW-1:0]            ram_wdata;
    logic [RAM_DW-1:0]            ram_rdata;
    logic                         ram_ack;

    modport slave (
        input  p_stb, p_we, p_addr, p_din, ram_rdata, ram_ack,
        output p_dout, p_ack, p_timeout, ram_stb, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output p_stb, p_we, p_addr, p_din, ram_rdata, ram_ack,
        input  p_dout, p_ack, p_timeout, ram_stb, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ramctrl_mp_rr_arbiter.sv
// rtl/ramctrl_mp_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
    import ramctrl_mp_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int GW = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        ptr,
    output logic [GW-1:0]        grant,
    output logic                 valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/ramctrl_mp.sv
// rtl/ramctrl_mp.sv - round-robin multi-port cache-line RAM controller with range check and watchdog
module ramctrl_mp
    import ramctrl_mp_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int RAM_DW      = 32,
    parameter int LINE_BEATS  = 2,
    parameter int LINE_AW     = 22,
    parameter int PORT_AW     = 26,
    parameter int WDOG_CYCLES = 255
) (
    input logic         clk,
    input logic         rst,
    ramctrl_mp_if.slave bus
);
    localparam int BB     = clog2(LINE_BEATS);
    localparam int LW     = LINE_BEATS * RAM_DW;
    localparam int RAM_AW = LINE_AW + BB;
    localparam int GW     = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
    localparam int WW     = (WDOG_CYCLES > 0) ? clog2(WDOG_CYCLES + 1) : 1;

    state_t               state_q, state_d;
    logic [GW-1:0]        rr_ptr_q, grant_q, arb_grant;
    logic                 arb_valid, we_q, oor_now, beat_last;
    logic [BB-1:0]        beat_q;
    logic [WW-1:0]        wdog_q;
    logic [LW-1:0]        p_dout_q;
    logic [NUM_PORTS-1:0] ack_d, timeout_d;
    logic                 ram_stb_d, ram_we_d;
    logic [RAM_AW-1:0]    ram_addr_d;
    logic [RAM_DW-1:0]    ram_wdata_d;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req   (bus.p_stb),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Any set bit above the in-range line field makes the request unserviceable.
    assign oor_now   = (bus.p_addr[int'(arb_grant)*PORT_AW +: PORT_AW] >> LINE_AW) != '0;
    assign beat_last = (beat_q == BB'(LINE_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ram_stb_d   = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ack_d       = '0;
        timeout_d   = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) state_d = oor_now ? ERR : XFER;
            end
            XFER: begin
                ram_stb_d   = 1'b1;
                ram_we_d    = we_q;
                ram_addr_d  = {bus.p_addr[int'(grant_q)*PORT_AW +: LINE_AW], beat_q};
                // Beat 0 carries the most significant word of the line.
                ram_wdata_d = bus.p_din[int'(grant_q)*LW + (LW - 1) - int'(beat_q)*RAM_DW -: RAM_DW];
                if (bus.ram_ack) begin
                    if (beat_last) state_d = DONE;
                end else if (WDOG_CYCLES != 0 && int'(wdog_q) + 1 == WDOG_CYCLES) begin
                    state_d = ABORT;
                end
            end
            DONE: begin
                ack_d[grant_q] = 1'b1;
                state_d        = IDLE;
            end
            ERR, ABORT: begin
                timeout_d[grant_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            we_q     <= 1'b0;
            beat_q   <= '0;
            wdog_q   <= '0;
            p_dout_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q  <= arb_grant;
                        we_q     <= bus.p_we[arb_grant];
                        rr_ptr_q <= (int'(arb_grant) == NUM_PORTS - 1) ? '0 : arb_grant + GW'(1);
                    end
                end
                XFER: begin
                    if (bus.ram_ack) begin
                        beat_q <= beat_q + BB'(1);
                        wdog_q <= '0;
                        if (!we_q) p_dout_q[(LW - 1) - int'(beat_q)*RAM_DW -: RAM_DW] <= bus.ram_rdata;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                ABORT: begin
                    beat_q <= '0;
                    wdog_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.p_dout    = p_dout_q;
    assign bus.p_ack     = ack_d;
    assign bus.p_timeout = timeout_d;
    assign bus.ram_stb   = ram_stb_d;
    assign bus.ram_we    = ram_we_d;
    assign bus.ram_addr  = ram_addr_d;
    assign bus.ram_wdata = ram_wdata_d;

endmodule

// File: tb/tb_ramctrl_mp.sv
// tb/tb_ramctrl_mp.sv - self-checking bench for ramctrl_mp with behavioural RAM and line model
module tb_ramctrl_mp;
    localparam int NP = 2, DW = 32, LB = 2, LAW = 22, PAW = 26, WD = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ramctrl_mp_if #(.NUM_PORTS(NP), .RAM_DW(DW), .LINE_BEATS(LB), .LINE_AW(LAW), .PORT_AW(PAW)) bus ();

    ramctrl_mp #(.NUM_PORTS(NP), .RAM_DW(DW), .LINE_BEATS(LB), .LINE_AW(LAW), .PORT_AW(PAW),
                 .WDOG_CYCLES(WD)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [22:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int          port;
        bit          we;
        logic [25:0] addr;
        logic [63:0] din;
        int          exp_cyc;
        logic [1:0]  exp_ack;
        logic [1:0]  exp_to;
        bit          chk_dout;
        logic [63:0] exp_dout;
    } vec_t;

    int total = 0, passed = 0;
    int max_wait = 0, wait_left = 0;
    bit ram_dead = 1'b0;
    int rr_next = 0;
    logic [31:0] mem [logic [22:0]];
    logic [63:0] ref_mem [logic [21:0]];
    wr_t wlog[$];
    vec_t vecs[7];

    // RAM model: decides ack for the coming edge on each falling edge
    always @(negedge clk) begin
        if (bus.ram_stb && !ram_dead && wait_left == 0) begin
            bus.ram_ack   = 1'b1;
            bus.ram_rdata = mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : 32'h0;
            if (bus.ram_we) begin
                mem[bus.ram_addr] = bus.ram_wdata;
                wlog.push_back('{bus.ram_addr, bus.ram_wdata});
            end
            wait_left = int'($urandom_range(max_wait, 0));
        end else begin
            bus.ram_ack = 1'b0;
            if (bus.ram_stb && !ram_dead) wait_left--;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] ref_line(input logic [21:0] l);
        return ref_mem.exists(l) ? ref_mem[l] : 64'h0;
    endfunction

    task automatic do_txn(input int port, input bit we, input logic [25:0] addr, input logic [63:0] din,
                          input int budget, output int resp_cyc, output logic [1:0] ack_v,
                          output logic [1:0] to_v, output int stb_cnt);
        bus.p_stb  = '0;
        bus.p_we   = '0;
        bus.p_addr = '0;
        bus.p_din  = '0;
        bus.p_we[port]             = we;
        bus.p_addr[port*PAW +: PAW] = addr;
        bus.p_din[port*64 +: 64]    = din;
        bus.p_stb[port]            = 1'b1;
        wlog.delete();
        resp_cyc = -1;
        ack_v    = '0;
        to_v     = '0;
        stb_cnt  = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ram_stb) stb_cnt++;
            if (bus.p_ack != '0 || bus.p_timeout != '0) begin
                resp_cyc = c;
                ack_v    = bus.p_ack;
                to_v     = bus.p_timeout;
                break;
            end
        end
        bus.p_stb = '0;
        rr_next   = (port + 1) % NP;
        @(posedge clk);
        @(negedge clk);
        check("pulse_single", {bus.p_ack, bus.p_timeout}, 4'h0);
    endtask

    initial begin
        int cyc, sc, got_n, exp_p, port;
        bit we, oor, found;
        logic [1:0] av, tv;
        logic [21:0] line;
        logic [25:0] addr;
        logic [63:0] din;

        vecs[0] = '{1, 1'b1, 26'h5,         64'h1111_2222_3333_4444, 3, 2'b10, 2'b00, 1'b0, 64'h0};
        vecs[1] = '{0, 1'b0, 26'h5,         64'h0,                   3, 2'b01, 2'b00, 1'b1, 64'h1111_2222_3333_4444};
        vecs[2] = '{0, 1'b0, 26'h040_0000,  64'h0,                   1, 2'b00, 2'b01, 1'b0, 64'h0};
        vecs[3] = '{1, 1'b1, 26'h03F_FFFF,  64'hA5A5_0F0F_5A5A_F0F0, 3, 2'b10, 2'b00, 1'b0, 64'h0};
        vecs[4] = '{0, 1'b0, 26'h03F_FFFF,  64'h0,                   3, 2'b01, 2'b00, 1'b1, 64'hA5A5_0F0F_5A5A_F0F0};
        vecs[5] = '{1, 1'b0, 26'h3FF_FFFF,  64'h0,                   1, 2'b00, 2'b10, 1'b0, 64'h0};
        vecs[6] = '{1, 1'b0, 26'h7,         64'h0,                   3, 2'b10, 2'b00, 1'b1, 64'h0};

        bus.p_stb = '0; bus.p_we = '0; bus.p_addr = '0; bus.p_din = '0;
        bus.ram_ack = 1'b0; bus.ram_rdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ram_stb", bus.ram_stb, 1'b0);
        check("rst_ram_we", bus.ram_we, 1'b0);
        check("rst_ram_addr", bus.ram_addr, 23'h0);
        check("rst_ram_wdata", bus.ram_wdata, 32'h0);
        check("rst_ack_to", {bus.p_ack, bus.p_timeout}, 4'h0);
        check("rst_p_dout", bus.p_dout, 64'h0);

        // table: single-port transactions with zero-wait RAM
        for (int i = 0; i < 7; i++) begin
            max_wait = 0; wait_left = 0;
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].din, 50, cyc, av, tv, sc);
            check($sformatf("vec%0d_cycle", i), cyc, vecs[i].exp_cyc);
            check($sformatf("vec%0d_ack", i), av, vecs[i].exp_ack);
            check($sformatf("vec%0d_timeout", i), tv, vecs[i].exp_to);
            check($sformatf("vec%0d_stb_cycles", i), sc, (vecs[i].exp_cyc == 1) ? 0 : 2);
            if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), bus.p_dout, vecs[i].exp_dout);
            if (vecs[i].we) begin
                check($sformatf("vec%0d_wr_count", i), wlog.size(), 2);
                if (wlog.size() == 2) begin
                    check($sformatf("vec%0d_wr0_addr", i), wlog[0].a, {vecs[i].addr[21:0], 1'b0});
                    check($sformatf("vec%0d_wr0_data", i), wlog[0].d, vecs[i].din[63:32]);
                    check($sformatf("vec%0d_wr1_addr", i), wlog[1].a, {vecs[i].addr[21:0], 1'b1});
                    check($sformatf("vec%0d_wr1_data", i), wlog[1].d, vecs[i].din[31:0]);
                end
                ref_mem[vecs[i].addr[21:0]] = vecs[i].din;
            end
        end

        // both ports requesting: grants must rotate
        max_wait = 0; wait_left = 0;
        bus.p_we = '0; bus.p_din = '0;
        bus.p_addr = {26'h3, 26'h5};
        bus.p_stb = 2'b11;
        got_n = 0;
        for (int c = 0; c < 200 && got_n < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.p_ack != '0 || bus.p_timeout != '0) begin
                exp_p = rr_next;
                check($sformatf("rr%0d_grant", got_n), {bus.p_ack, bus.p_timeout}, {2'(1 << exp_p), 2'b00});
                check($sformatf("rr%0d_dout", got_n), bus.p_dout, ref_line((exp_p == 0) ? 22'h5 : 22'h3));
                rr_next = (exp_p + 1) % NP;
                got_n++;
            end
        end
        check("rr_count", got_n, 4);
        bus.p_stb = '0;
        @(posedge clk);
        @(negedge clk);

        // dead RAM: watchdog abort, then normal service resumes
        ram_dead = 1'b1;
        do_txn(1, 1'b0, 26'h2, 64'h0, 400, cyc, av, tv, sc);
        check("wdog_timeout", tv, 2'b10);
        check("wdog_ack", av, 2'b00);
        check("wdog_stb_cycles", sc, WD);
        check("wdog_cycle", cyc, WD + 1);
        ram_dead = 1'b0; wait_left = 0;
        do_txn(0, 1'b0, 26'h5, 64'h0, 50, cyc, av, tv, sc);
        check("post_wdog_ack", av, 2'b01);
        check("post_wdog_cycle", cyc, 3);
        check("post_wdog_dout", bus.p_dout, 64'h1111_2222_3333_4444);

        // reset during beat 1 of a read
        max_wait = 0; wait_left = 0;
        bus.p_addr = {26'h0, 26'h5};
        bus.p_we = '0;
        bus.p_stb = 2'b01;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ram_stb && bus.ram_addr[0]) found = 1'b1;
        end
        check("rst_mid_found_beat1", found, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ram_stb", bus.ram_stb, 1'b0);
        check("rst_mid_ack_to", {bus.p_ack, bus.p_timeout}, 4'h0);
        check("rst_mid_dout", bus.p_dout, 64'h0);
        rst = 1'b0;
        bus.p_stb = '0;
        rr_next = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_no_ack", {bus.p_ack, bus.p_timeout}, 4'h0);
        do_txn(1, 1'b0, 26'h5, 64'h0, 50, cyc, av, tv, sc);
        check("post_rst_ack", av, 2'b10);
        check("post_rst_cycle", cyc, 3);
        check("post_rst_dout", bus.p_dout, 64'h1111_2222_3333_4444);

        // randomized single-port traffic against the line model
        for (int n = 0; n < 40; n++) begin
            port = int'($urandom_range(NP - 1, 0));
            we   = 1'($urandom_range(1, 0));
            line = 22'($urandom_range(7, 0));
            oor  = ($urandom_range(5, 0) == 0);
            addr = {oor ? 4'($urandom_range(15, 1)) : 4'd0, line};
            din  = {$urandom, $urandom};
            max_wait  = int'($urandom_range(2, 0));
            wait_left = int'($urandom_range(max_wait, 0));
            do_txn(port, we, addr, din, 100, cyc, av, tv, sc);
            if (oor) begin
                check($sformatf("rnd%0d_oor_to", n), {av, tv}, {2'b00, 2'(1 << port)});
                check($sformatf("rnd%0d_oor_cycle", n), cyc, 1);
                check($sformatf("rnd%0d_oor_stb", n), sc, 0);
            end else begin
                check($sformatf("rnd%0d_ack", n), {av, tv}, {2'(1 << port), 2'b00});
                if (max_wait == 0) check($sformatf("rnd%0d_cycle", n), cyc, 3);
                if (!we) begin
                    check($sformatf("rnd%0d_dout", n), bus.p_dout, ref_line(line));
                end else begin
                    check($sformatf("rnd%0d_wr_count", n), wlog.size(), 2);
                    if (wlog.size() == 2)
                        check($sformatf("rnd%0d_wr_data", n), {wlog[0].d, wlog[1].d}, din);
                    ref_mem[line] = din;
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
